// File: rtl/bridge_pkg.sv
// Shared command codes, decoder state encoding and helpers
// for the I2C-slave to SPI/I2C-master command bridge.
package bridge_pkg;

    localparam logic [7:0] CMD_SPI_CODE = 8'h01;
    localparam logic [7:0] CMD_I2C_CODE = 8'h02;
    localparam logic [6:0] DEF_ADDR     = 7'h50;

    typedef enum logic [2:0] {
        IDLE,
        SPI_DATA,
        I2C_ADDR,
        I2C_DATA,
        DISCARD
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/byte_hold_reg.sv
// One-entry valid/ready byte holding register; a load that
// finds the entry full and not draining is dropped and flagged.
module byte_hold_reg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] din,
    input  logic       ready,
    output logic [7:0] data,
    output logic       valid,
    output logic       ovf,
    output logic       taken
);

    assign taken = load && (!valid || ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= 8'h00;
            valid <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            ovf <= load && valid && !ready;
            if (taken) begin
                data  <= din;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_decoder.sv
// Routes bytes from the I2C slave to the SPI or I2C master channel
// according to the leading command byte of each transaction.
module i2c_cmd_decoder
    import bridge_pkg::*;
#(
    parameter logic [7:0] CMD_SPI      = CMD_SPI_CODE,
    parameter logic [7:0] CMD_I2C      = CMD_I2C_CODE,
    parameter logic [6:0] DEF_I2C_ADDR = DEF_ADDR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       busy,
    output logic [7:0] spi_data,
    output logic       spi_valid,
    input  logic       spi_ready,
    output logic [7:0] i2cm_data,
    output logic       i2cm_valid,
    input  logic       i2cm_ready,
    output logic [6:0] i2cm_addr,
    output logic [7:0] byte_count,
    output logic       err_cmd,
    output logic       err_ovf,
    output logic       frame_done
);

    state_t state_q;
    state_t state_d;
    logic   busy_q;
    logic   busy_fall;
    logic   spi_load;
    logic   i2c_load;
    logic   addr_load;
    logic   bad_cmd;
    logic   spi_ovf;
    logic   i2c_ovf;
    logic   spi_taken;
    logic   i2c_taken;

    assign busy_fall = busy_q && !busy;
    assign err_ovf   = spi_ovf || i2c_ovf;

    always_comb begin
        state_d   = state_q;
        spi_load  = 1'b0;
        i2c_load  = 1'b0;
        addr_load = 1'b0;
        bad_cmd   = 1'b0;
        if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == CMD_SPI) begin
                        state_d = SPI_DATA;
                    end else if (rx_data == CMD_I2C) begin
                        state_d = I2C_ADDR;
                    end else begin
                        state_d = DISCARD;
                        bad_cmd = 1'b1;
                    end
                end
                SPI_DATA: spi_load = 1'b1;
                I2C_ADDR: begin
                    addr_load = 1'b1;
                    state_d   = I2C_DATA;
                end
                I2C_DATA: i2c_load = 1'b1;
                default:  ;
            endcase
        end
        // The byte of the ending cycle is handled above first.
        if (busy_fall) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            i2cm_addr  <= DEF_I2C_ADDR;
            byte_count <= 8'h00;
            err_cmd    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy;
            err_cmd    <= bad_cmd;
            frame_done <= busy_fall;
            if (addr_load) begin
                i2cm_addr <= rx_data[6:0];
            end
            // Count stays visible for the frame_done cycle, then clears.
            if (frame_done) begin
                byte_count <= 8'h00;
            end else if (spi_taken || i2c_taken) begin
                byte_count <= sat_inc(byte_count);
            end
        end
    end

    byte_hold_reg u_spi_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (spi_load),
        .din   (rx_data),
        .ready (spi_ready),
        .data  (spi_data),
        .valid (spi_valid),
        .ovf   (spi_ovf),
        .taken (spi_taken)
    );

    byte_hold_reg u_i2c_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (i2c_load),
        .din   (rx_data),
        .ready (i2cm_ready),
        .data  (i2cm_data),
        .valid (i2cm_valid),
        .ovf   (i2c_ovf),
        .taken (i2c_taken)
    );

endmodule

// File: doc/i2c_cmd_decoder.md
I2C_CMD_DECODER -- requirements
Module: i2c_cmd_decoder

Interface
REQ-001 SHALL have parameter CMD_SPI, default 8'h01, meaning command byte that routes the following data to the SPI-master channel.
REQ-002 SHALL have parameter CMD_I2C, default 8'h02, meaning command byte that routes the following data to the I2C-master channel.
REQ-003 SHALL have parameter DEF_I2C_ADDR, default 7'h50, meaning the I2C target address after reset.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, meaning the asynchronous active-low reset.
REQ-006 SHALL have ports rx_data (input, 8 bits) and rx_valid (input, 1 bit), meaning the byte stream from the I2C slave; rx_valid is a 1-cycle strobe.
REQ-007 SHALL have port busy, input, 1 bit, meaning the I2C slave transaction is active; its falling edge marks end of transaction.
REQ-008 SHALL have ports spi_data (output, 8), spi_valid (output, 1) and spi_ready (input, 1), meaning the valid/ready byte stream to the SPI-master side.
REQ-009 SHALL have ports i2cm_data (output, 8), i2cm_valid (output, 1), i2cm_ready (input, 1) and i2cm_addr (output, 7), meaning the byte stream and target address to the I2C-master side.
REQ-010 SHALL have ports byte_count (output, 8), err_cmd (output, 1), err_ovf (output, 1) and frame_done (output, 1), meaning status and error outputs.

Function
REQ-011 SHALL implement states IDLE, SPI_DATA, I2C_ADDR, I2C_DATA and DISCARD.
REQ-012 In IDLE, SHALL on rx_valid move to SPI_DATA if rx_data==CMD_SPI, to I2C_ADDR if rx_data==CMD_I2C, and otherwise to DISCARD with a 1-cycle err_cmd pulse.
REQ-013 In I2C_ADDR, SHALL on rx_valid latch rx_data[6:0] into i2cm_addr, ignore bit 7, and move to I2C_DATA.
REQ-014 In SPI_DATA or I2C_DATA, SHALL on rx_valid load the byte into that channel's holding register.
REQ-015 In DISCARD, SHALL drop received bytes silently.
REQ-016 SHALL give a latency of exactly 1 cycle: a byte loaded on cycle N is presented with valid high on cycle N+1.
REQ-017 Once valid is asserted, SHALL hold valid and data stable until the cycle in which ready is high.
REQ-018 If valid&&ready and a new byte loads in the same cycle, SHALL keep valid high and present the new data with no bubble.
REQ-019 If a byte arrives for a channel whose holding register is valid and ready is low, SHALL drop the byte, pulse err_ovf for 1 cycle, keep the held data, and not increment byte_count.
REQ-020 SHALL increment byte_count, saturating at 255, for each data byte loaded into either holding register; command and address bytes are not counted.
REQ-021 On a busy falling edge, detected against a registered copy of busy, SHALL return to IDLE from any state, pulse frame_done for 1 cycle, and clear byte_count to 0 on the next cycle.
REQ-022 If rx_valid coincides with the busy falling edge, SHALL first process the byte in the current state; the state then goes to IDLE and byte_count clears after counting it.
REQ-023 SHALL not flush a pending holding register at end of transaction; it stays valid until accepted.
REQ-024 SHALL keep i2cm_addr across transactions until the next I2C_ADDR byte.
REQ-025 A frame ending in I2C_ADDR (no address byte received) SHALL leave i2cm_addr unchanged.

Reset
REQ-026 On rst_n low, SHALL asynchronously set state=IDLE, spi_valid=0, i2cm_valid=0, spi_data=0, i2cm_data=0, i2cm_addr=DEF_I2C_ADDR, byte_count=0, err_cmd=0, err_ovf=0, frame_done=0 and busy history=0.
REQ-027 On reset mid-transfer, SHALL discard held bytes; after release, bytes are ignored as commands only per REQ-012 (the first byte after reset is treated as a command).

Structure
REQ-028 SHALL place command codes (8'h01, 8'h02) and the state encoding in the shared package bridge_pkg.
REQ-029 SHALL instantiate one sub-module, byte_hold_reg (8-bit valid/ready holding register with overflow flag), twice: once for the SPI channel and once for the I2C channel.

Verification
REQ-030 Stimulus: bytes 01,A5,3C with spi_ready=1. Required response: spi_data A5 then 3C each 1 cycle after rx_valid; byte_count=2; frame_done on busy fall.
REQ-031 Stimulus: bytes 02,D2,11,22. Required response: i2cm_addr=7'h52; i2cm_data 11 then 22; spi_valid stays 0.
REQ-032 Stimulus: bytes 07,55,66. Required response: err_cmd pulses once; no valid on either channel; byte_count=0.
REQ-033 Stimulus: 01,10,20 with spi_ready=0. Required response: spi_data holds 10; err_ovf pulses on byte 20; after ready rises, 10 accepted and valid drops.
REQ-034 Stimulus: rx_valid(02 frame data byte 99) on the same cycle as busy falls. Required response: 99 delivered; frame_done pulses; next byte 01 is decoded as a command.
REQ-035 Stimulus: rst_n low while i2cm_valid=1. Required response: all outputs at REQ-026 values; i2cm_addr=7'h50.
